// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder/scan controller.
// Holds the FSM state encoding and the one-hot expansion used for every decode.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Widest select the helper supports; callers truncate the result to 2**N bits.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    onehot = MAX_OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for the scan sequencer: counts 0..DWELL-1 and flags the last
// count with tick so the caller can advance its index.
module scan_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == CW'(DWELL - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Registered one-hot decoder with a direct-select mode and an auto-scan mode
// that walks every output bit, holding each one for DWELL cycles.
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2**N-1:0] out,
  output logic            out_valid,
  output logic            wrap
);

  localparam int OUTW = 2 ** N;

  state_e         state_q, state_d;
  logic [N-1:0]   index_q, index_d;
  logic [OUTW-1:0] out_q, out_d;
  logic           outValid_q, outValid_d;
  logic           wrap_q, wrap_d;

  logic           handshake;
  logic           dwellClr;
  logic           dwellTick;

  assign in_ready  = (state_q == DIRECT);
  assign handshake = in_valid && in_ready;

  // The dwell count only runs while the scan continues; any exit or fresh entry restarts it at zero.
  assign dwellClr = !(en && mode && (state_q == SCAN));

  scan_timer #(
    .DWELL(DWELL)
  ) u_scan_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (dwellClr),
    .tick (dwellTick)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    out_d      = out_q;
    outValid_d = outValid_q;
    wrap_d     = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      index_d    = '0;
      out_d      = '0;
      outValid_d = 1'b0;
    end else if (!mode) begin
      state_d = DIRECT;
      index_d = '0;
      if (state_q != DIRECT) begin
        out_d      = '0;
        outValid_d = 1'b0;
      end else if (handshake) begin
        out_d      = OUTW'(onehot(MAX_SEL_W'(in)));
        outValid_d = 1'b1;
      end
    end else begin
      state_d = SCAN;
      // Entering the scan always shows bit 0 immediately, even when coming from DIRECT.
      if (state_q != SCAN) begin
        index_d    = '0;
        out_d      = OUTW'(onehot('0));
        outValid_d = 1'b1;
      end else if (dwellTick) begin
        index_d    = index_q + 1'b1;
        out_d      = OUTW'(onehot(MAX_SEL_W'(index_d)));
        outValid_d = 1'b1;
        wrap_d     = (index_q == '1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      index_q    <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign wrap      = wrap_q;

endmodule
